// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer scheduler for the DDR3 frame store: hands out write/read
// regions and rotates them on frame boundaries so reads never see partial frames.
module frame_buffer_scheduler #(
    parameter int unsigned FRAME_PHRASES = 115200,
    parameter int unsigned BASE_PHRASE   = 0,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             init_calib_complete,
    input  logic             wr_sof_in,
    input  logic             wr_eof_in,
    input  logic             rd_sof_in,
    output logic [26:0]      wr_base_out,
    output logic [26:0]      rd_base_out,
    output logic [1:0]       wr_buf_out,
    output logic [1:0]       rd_buf_out,
    output logic             fresh_out,
    output logic             wr_active_out,
    output logic [CNT_W-1:0] frames_written_out,
    output logic [CNT_W-1:0] frames_dropped_out,
    output logic [CNT_W-1:0] frames_repeated_out,
    output logic [CNT_W-1:0] frames_aborted_out,
    output logic             ready_out
);

    localparam logic [0:0] S_WAIT_CAL = 1'b0;
    localparam logic [0:0] S_RUN      = 1'b1;

    localparam logic [26:0] L_BASE0 = 27'(BASE_PHRASE);
    localparam logic [26:0] L_BASE1 = 27'(BASE_PHRASE + FRAME_PHRASES);
    localparam logic [26:0] L_BASE2 = 27'(BASE_PHRASE + 2 * FRAME_PHRASES);

    if (64'(BASE_PHRASE) + 64'(3) * 64'(FRAME_PHRASES) > 64'd134217728) begin : g_bad_cfg
        $error("frame_buffer_scheduler: three buffers exceed 27-bit phrase space");
    end

    logic [0:0]       r_state;
    logic [1:0]       r_wr_idx;
    logic [1:0]       r_rd_idx;
    logic [1:0]       r_sp_idx;
    logic             r_fresh;
    logic             r_wr_active;
    logic             r_ready;
    logic [26:0]      r_wr_base;
    logic [26:0]      r_rd_base;
    logic [CNT_W-1:0] r_written;
    logic [CNT_W-1:0] r_dropped;
    logic [CNT_W-1:0] r_repeated;
    logic [CNT_W-1:0] r_aborted;

    logic [0:0]       w_state_nxt;
    logic [1:0]       w_wr_nxt;
    logic [1:0]       w_rd_nxt;
    logic [1:0]       w_sp_nxt;
    logic             w_fresh_nxt;
    logic             w_act_nxt;
    logic [CNT_W-1:0] w_written_nxt;
    logic [CNT_W-1:0] w_dropped_nxt;
    logic [CNT_W-1:0] w_repeated_nxt;
    logic [CNT_W-1:0] w_aborted_nxt;

    function automatic logic [CNT_W-1:0] f_sat(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [26:0] f_base(input logic [1:0] idx);
        case (idx)
            2'd0:    return L_BASE0;
            2'd1:    return L_BASE1;
            default: return L_BASE2;
        endcase
    endfunction

    // Events apply in order sof -> eof -> rd_sof; each sees the previous result.
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_nxt       = r_wr_idx;
        w_rd_nxt       = r_rd_idx;
        w_sp_nxt       = r_sp_idx;
        w_fresh_nxt    = r_fresh;
        w_act_nxt      = r_wr_active;
        w_written_nxt  = r_written;
        w_dropped_nxt  = r_dropped;
        w_repeated_nxt = r_repeated;
        w_aborted_nxt  = r_aborted;
        if (r_state == S_WAIT_CAL) begin
            if (init_calib_complete) begin
                w_state_nxt = S_RUN;
            end
        end else if (!init_calib_complete) begin
            w_state_nxt = S_WAIT_CAL;
            w_act_nxt   = 1'b0;
        end else begin
            if (wr_sof_in) begin
                if (r_wr_active) begin
                    w_aborted_nxt = f_sat(r_aborted);
                end
                w_act_nxt = 1'b1;
            end
            if (wr_eof_in && w_act_nxt) begin
                w_wr_nxt = r_sp_idx;
                w_sp_nxt = r_wr_idx;
                if (r_fresh) begin
                    w_dropped_nxt = f_sat(r_dropped);
                end
                w_fresh_nxt   = 1'b1;
                w_written_nxt = f_sat(r_written);
                w_act_nxt     = 1'b0;
            end
            if (rd_sof_in) begin
                if (w_fresh_nxt) begin
                    w_rd_nxt    = w_sp_nxt;
                    w_sp_nxt    = r_rd_idx;
                    w_fresh_nxt = 1'b0;
                end else begin
                    w_repeated_nxt = f_sat(r_repeated);
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= S_WAIT_CAL;
            r_wr_idx    <= 2'd0;
            r_rd_idx    <= 2'd1;
            r_sp_idx    <= 2'd2;
            r_fresh     <= 1'b0;
            r_wr_active <= 1'b0;
            r_ready     <= 1'b0;
            r_wr_base   <= L_BASE0;
            r_rd_base   <= L_BASE1;
            r_written   <= '0;
            r_dropped   <= '0;
            r_repeated  <= '0;
            r_aborted   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_idx    <= w_wr_nxt;
            r_rd_idx    <= w_rd_nxt;
            r_sp_idx    <= w_sp_nxt;
            r_fresh     <= w_fresh_nxt;
            r_wr_active <= w_act_nxt;
            r_ready     <= (w_state_nxt == S_RUN);
            r_wr_base   <= f_base(w_wr_nxt);
            r_rd_base   <= f_base(w_rd_nxt);
            r_written   <= w_written_nxt;
            r_dropped   <= w_dropped_nxt;
            r_repeated  <= w_repeated_nxt;
            r_aborted   <= w_aborted_nxt;
        end
    end

    assign wr_base_out         = r_wr_base;
    assign rd_base_out         = r_rd_base;
    assign wr_buf_out          = r_wr_idx;
    assign rd_buf_out          = r_rd_idx;
    assign fresh_out           = r_fresh;
    assign wr_active_out       = r_wr_active;
    assign frames_written_out  = r_written;
    assign frames_dropped_out  = r_dropped;
    assign frames_repeated_out = r_repeated;
    assign frames_aborted_out  = r_aborted;
    assign ready_out           = r_ready;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Scoreboard bench for frame_buffer_scheduler: per-step expected snapshots
// are queued with the stimulus and compared after the clock edge.
module tb_frame_buffer_scheduler;

    localparam int unsigned FP = 115200;
    localparam int unsigned BP = 0;
    localparam int OW = 125;

    // stimulus code: {calib, wr_sof, wr_eof, rd_sof}
    localparam logic [3:0] C_I  = 4'h8;
    localparam logic [3:0] C_S  = 4'hC;
    localparam logic [3:0] C_E  = 4'hA;
    localparam logic [3:0] C_R  = 4'h9;
    localparam logic [3:0] C_ER = 4'hB;
    localparam logic [3:0] C_SE = 4'hE;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        init_calib_complete = 1'b0;
    logic        wr_sof_in = 1'b0;
    logic        wr_eof_in = 1'b0;
    logic        rd_sof_in = 1'b0;
    logic [26:0] wr_base_out;
    logic [26:0] rd_base_out;
    logic [1:0]  wr_buf_out;
    logic [1:0]  rd_buf_out;
    logic        fresh_out;
    logic        wr_active_out;
    logic [15:0] frames_written_out;
    logic [15:0] frames_dropped_out;
    logic [15:0] frames_repeated_out;
    logic [15:0] frames_aborted_out;
    logic        ready_out;

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] sb[$];
    logic [OW-1:0] obs;

    frame_buffer_scheduler dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .init_calib_complete (init_calib_complete),
        .wr_sof_in           (wr_sof_in),
        .wr_eof_in           (wr_eof_in),
        .rd_sof_in           (rd_sof_in),
        .wr_base_out         (wr_base_out),
        .rd_base_out         (rd_base_out),
        .wr_buf_out          (wr_buf_out),
        .rd_buf_out          (rd_buf_out),
        .fresh_out           (fresh_out),
        .wr_active_out       (wr_active_out),
        .frames_written_out  (frames_written_out),
        .frames_dropped_out  (frames_dropped_out),
        .frames_repeated_out (frames_repeated_out),
        .frames_aborted_out  (frames_aborted_out),
        .ready_out           (ready_out)
    );

    always #5 clk_in = ~clk_in;

    assign obs = {ready_out, wr_active_out, fresh_out, wr_buf_out, rd_buf_out,
                  wr_base_out, rd_base_out, frames_written_out, frames_dropped_out,
                  frames_repeated_out, frames_aborted_out};

    function automatic logic [OW-1:0] mk(input logic rdy, input logic act,
                                         input logic fr, input logic [1:0] wb,
                                         input logic [1:0] rb, input int wr,
                                         input int dr, input int rp, input int ab);
        logic [26:0] bw;
        logic [26:0] br;
        bw = 27'(BP) + 27'(FP) * 27'(wb);
        br = 27'(BP) + 27'(FP) * 27'(rb);
        return {rdy, act, fr, wb, rb, bw, br, 16'(wr), 16'(dr), 16'(rp), 16'(ab)};
    endfunction

    task automatic do_reset();
        rst_in = 1'b1;
        init_calib_complete = 1'b0;
        {wr_sof_in, wr_eof_in, rd_sof_in} = 3'b000;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic step(input logic [3:0] s);
        {init_calib_complete, wr_sof_in, wr_eof_in, rd_sof_in} = s;
        @(negedge clk_in);
        {wr_sof_in, wr_eof_in, rd_sof_in} = 3'b000;
    endtask

    task automatic test_reset();
        logic [OW-1:0] e;
        rst_in = 1'b1;
        @(negedge clk_in);
        sb.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_state obs=%h exp=%h", obs, e);
        end
        rst_in = 1'b0;
        sb.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
        step(C_I);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL calib_ready obs=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_precal();
        logic [3:0]    st [6];
        logic [OW-1:0] ex [6];
        logic [OW-1:0] e;
        logic [OW-1:0] rs;
        do_reset();
        rs = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
        st = '{4'h4, 4'h2, 4'h1, 4'h6, 4'h7, C_I};
        ex = '{rs, rs, rs, rs, rs, mk(1, 0, 0, 0, 1, 0, 0, 0, 0)};
        for (int i = 0; i < 6; i++) begin
            sb.push_back(ex[i]);
            step(st[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL precal[%0d] obs=%h exp=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_frame();
        logic [3:0]    st [13];
        logic [OW-1:0] ex [13];
        logic [OW-1:0] e;
        logic [OW-1:0] a;
        do_reset();
        a = mk(1, 1, 0, 0, 1, 0, 0, 0, 0);
        st = '{C_I, C_S, C_I, C_I, C_I, C_I, C_I, C_I, C_I, C_I, C_I, C_E, C_R};
        ex = '{mk(1, 0, 0, 0, 1, 0, 0, 0, 0), a, a, a, a, a, a, a, a, a, a,
               mk(1, 0, 1, 2, 1, 1, 0, 0, 0),
               mk(1, 0, 0, 2, 0, 1, 0, 0, 0)};
        for (int i = 0; i < 13; i++) begin
            sb.push_back(ex[i]);
            step(st[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL frame[%0d] obs=%h exp=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_drop();
        logic [3:0]    st [6];
        logic [OW-1:0] ex [6];
        logic [OW-1:0] e;
        do_reset();
        st = '{C_I, C_S, C_E, C_S, C_E, C_R};
        ex = '{mk(1, 0, 0, 0, 1, 0, 0, 0, 0),
               mk(1, 1, 0, 0, 1, 0, 0, 0, 0),
               mk(1, 0, 1, 2, 1, 1, 0, 0, 0),
               mk(1, 1, 1, 2, 1, 1, 0, 0, 0),
               mk(1, 0, 1, 0, 1, 2, 1, 0, 0),
               mk(1, 0, 0, 0, 2, 2, 1, 0, 0)};
        for (int i = 0; i < 6; i++) begin
            sb.push_back(ex[i]);
            step(st[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL drop[%0d] obs=%h exp=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_repeat_abort();
        logic [3:0]    st [8];
        logic [OW-1:0] ex [8];
        logic [OW-1:0] e;
        do_reset();
        st = '{C_I, C_R, C_R, C_R, C_S, C_S, 4'h0, C_I};
        ex = '{mk(1, 0, 0, 0, 1, 0, 0, 0, 0),
               mk(1, 0, 0, 0, 1, 0, 0, 1, 0),
               mk(1, 0, 0, 0, 1, 0, 0, 2, 0),
               mk(1, 0, 0, 0, 1, 0, 0, 3, 0),
               mk(1, 1, 0, 0, 1, 0, 0, 3, 0),
               mk(1, 1, 0, 0, 1, 0, 0, 3, 1),
               mk(0, 0, 0, 0, 1, 0, 0, 3, 1),
               mk(1, 0, 0, 0, 1, 0, 0, 3, 1)};
        for (int i = 0; i < 8; i++) begin
            sb.push_back(ex[i]);
            step(st[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL repeat_abort[%0d] obs=%h exp=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]    st [6];
        logic [OW-1:0] ex [6];
        logic [OW-1:0] e;
        do_reset();
        st = '{C_I, C_S, C_ER, C_S, C_SE, C_S};
        ex = '{mk(1, 0, 0, 0, 1, 0, 0, 0, 0),
               mk(1, 1, 0, 0, 1, 0, 0, 0, 0),
               mk(1, 0, 0, 2, 0, 1, 0, 0, 0),
               mk(1, 1, 0, 2, 0, 1, 0, 0, 0),
               mk(1, 0, 1, 1, 0, 2, 0, 0, 1),
               mk(1, 1, 1, 1, 0, 2, 0, 0, 1)};
        for (int i = 0; i < 6; i++) begin
            sb.push_back(ex[i]);
            step(st[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d] obs=%h exp=%h", i, obs, e);
            end
        end
        // asynchronous reset between clock edges, mid-write
        #2 rst_in = 1'b1;
        sb.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
        #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL async_reset obs=%h exp=%h", obs, e);
        end
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_precal();
        test_frame();
        test_drop();
        test_repeat_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
